// File: rtl/cp0_hazard_ctrl.sv
// CP0 hazard scoreboard: tracks in-flight MTC0 writes, resolves MFC0 reads in ID, retires writes.
// Build option: define CP0_FWD_EN to forward completed in-flight writes instead of stalling until retire.
module cp0_hazard_ctrl #(
  parameter int DEPTH     = 3,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int STALL_MAX = 15,
  localparam int CNT_W    = $clog2(STALL_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_cp0_r_en,
  input  logic [ADDR_W-1:0] id_cp0_r_addr,
  input  logic              id_cp0_w_en,
  input  logic [ADDR_W-1:0] id_cp0_w_addr,
  input  logic              pipe_advance,
  input  logic              ex_done,
  input  logic [DATA_W-1:0] ex_w_data,
  input  logic              flush,
  input  logic [DATA_W-1:0] cp0_rf_data,
  output logic              id_stall,
  output logic [DATA_W-1:0] id_cp0_data,
  output logic              wb_w_en,
  output logic [ADDR_W-1:0] wb_w_addr,
  output logic [DATA_W-1:0] wb_w_data,
  output logic              stall_timeout
);

  // state | meaning
  // IDLE  | ID not stalled on a CP0 hazard, cnt = 0
  // WAIT  | ID stalled; cnt counts stalled cycles, saturating at STALL_MAX
  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);

  logic              slot_en   [DEPTH];
  logic [ADDR_W-1:0] slot_addr [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];
`ifdef CP0_FWD_EN
  logic              slot_done [DEPTH];
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_nxt;
  logic             hit;
  logic             in_en;
  logic             in_done;

`ifdef CP0_FWD_EN
  logic              hit_done;
  logic [DATA_W-1:0] hit_data;

  // Scan oldest to youngest so the youngest matching slot is left standing.
  always_comb begin
    hit      = 1'b0;
    hit_done = 1'b0;
    hit_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_en[i] && slot_addr[i] == id_cp0_r_addr) begin
        hit      = 1'b1;
        hit_done = slot_done[i];
        hit_data = slot_data[i];
      end
    end
    id_stall    = id_valid && id_cp0_r_en && hit && !hit_done && !flush;
    id_cp0_data = !id_cp0_r_en ? '0 : ((hit && hit_done) ? hit_data : cp0_rf_data);
  end
`else
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_en[i] && slot_addr[i] == id_cp0_r_addr) hit = 1'b1;
    end
    id_stall    = id_valid && id_cp0_r_en && hit && !flush;
    id_cp0_data = id_cp0_r_en ? cp0_rf_data : '0;
  end
`endif

  assign in_en   = id_valid && id_cp0_w_en && !id_stall;
  assign in_done = in_en && ex_done;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_en[i]   <= 1'b0;
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
`ifdef CP0_FWD_EN
        slot_done[i] <= 1'b0;
`endif
      end
      wb_w_en   <= 1'b0;
      wb_w_addr <= '0;
      wb_w_data <= '0;
    end else begin
      wb_w_en <= 1'b0;
      if (pipe_advance) begin
        wb_w_en   <= slot_en[DEPTH-1];
        wb_w_addr <= slot_addr[DEPTH-1];
        wb_w_data <= slot_data[DEPTH-1];
        for (int i = DEPTH - 1; i > 0; i--) begin
          slot_en[i]   <= slot_en[i-1];
          slot_addr[i] <= slot_addr[i-1];
          slot_data[i] <= slot_data[i-1];
`ifdef CP0_FWD_EN
          slot_done[i] <= slot_done[i-1];
`endif
        end
        slot_en[0]   <= in_en;
        slot_addr[0] <= id_cp0_w_addr;
        slot_data[0] <= in_done ? ex_w_data : '0;
`ifdef CP0_FWD_EN
        slot_done[0] <= in_done;
`endif
      end else if (ex_done && slot_en[0]) begin
        slot_data[0] <= ex_w_data;
`ifdef CP0_FWD_EN
        slot_done[0] <= 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (id_stall) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (id_stall) begin
          if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    timeout_nxt = (cnt_nxt == CNT_MAX) && (cnt != CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state         <= IDLE;
      cnt           <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      stall_timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_cp0_hazard_ctrl.sv
// Randomized bench for cp0_hazard_ctrl: queue-based reference model plus a retire scoreboard.
module tb_cp0_hazard_ctrl;
  localparam int DEPTH     = 3;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int STALL_MAX = 15;

  logic              clk;
  logic              rst;
  logic              id_valid, id_cp0_r_en, id_cp0_w_en;
  logic [ADDR_W-1:0] id_cp0_r_addr, id_cp0_w_addr;
  logic              pipe_advance, ex_done, flush;
  logic [DATA_W-1:0] ex_w_data, cp0_rf_data;
  logic              id_stall, wb_w_en, stall_timeout;
  logic [DATA_W-1:0] id_cp0_data, wb_w_data;
  logic [ADDR_W-1:0] wb_w_addr;

  cp0_hazard_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_cp0_r_en(id_cp0_r_en), .id_cp0_r_addr(id_cp0_r_addr),
    .id_cp0_w_en(id_cp0_w_en), .id_cp0_w_addr(id_cp0_w_addr),
    .pipe_advance(pipe_advance), .ex_done(ex_done), .ex_w_data(ex_w_data),
    .flush(flush), .cp0_rf_data(cp0_rf_data),
    .id_stall(id_stall), .id_cp0_data(id_cp0_data),
    .wb_w_en(wb_w_en), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {bit en; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; bit done;} wr_t;
  typedef struct {int cyc; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} ret_t;

  wr_t  mq[$];   // in-flight writes, index 0 = youngest (EX)
  ret_t rq[$];   // expected retire strobes
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   run = 0; // consecutive stalled cycles so far
  bit   mon_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    wr_t e;
    e = '{default: 0};
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(e);
  endtask

  task automatic step(input bit v, input bit re, input logic [ADDR_W-1:0] ra,
                      input bit we, input logic [ADDR_W-1:0] wa,
                      input bit adv_in, input bit dn, input logic [DATA_W-1:0] wd,
                      input bit fl, input logic [DATA_W-1:0] rf, input bit rs);
    bit hit, hdone, estall, adv;
    logic [DATA_W-1:0] hdata, edata;
    wr_t ne, old;
    @(negedge clk);
    // EX holds while it owes data, so only finished writes travel past slot 0.
    adv = adv_in && !(mq[0].en && !mq[0].done);
    id_valid = v; id_cp0_r_en = re; id_cp0_r_addr = ra;
    id_cp0_w_en = we; id_cp0_w_addr = wa;
    pipe_advance = adv; ex_done = dn; ex_w_data = wd;
    flush = fl; cp0_rf_data = rf; rst = rs;
    #1;
    hit = 0; hdone = 0; hdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mq[i].en && mq[i].addr == ra) begin
        hit = 1; hdone = mq[i].done; hdata = mq[i].data;
        break;
      end
    end
`ifdef CP0_FWD_EN
    estall = v && re && hit && !hdone && !fl;
    edata  = !re ? '0 : ((hit && hdone) ? hdata : rf);
`else
    estall = v && re && hit && !fl;
    edata  = re ? rf : '0;
`endif
    if (!rs) begin
      check("id_stall", id_stall, estall);
      check("id_cp0_data", id_cp0_data, edata);
      check("stall_timeout", stall_timeout, run == STALL_MAX);
    end
    if (rs || fl) begin
      model_reset();
      run = 0;
    end else begin
      run = estall ? run + 1 : 0;
      if (adv) begin
        old = mq.pop_back();
        if (old.en && !old.done) begin
          n_fail++;
          $display("FAIL retire_undone: addr %h retired without data (cycle %0d)", old.addr, cyc);
        end
        if (old.en) rq.push_back('{cyc + 1, old.addr, old.data});
        ne.en   = v && we && !estall;
        ne.addr = wa;
        ne.done = ne.en && dn;
        ne.data = ne.done ? wd : '0;
        mq.push_front(ne);
      end else if (dn && mq[0].en) begin
        mq[0].data = wd;
        mq[0].done = 1;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    ret_t e;
    if (mon_on) begin
      if (wb_w_en !== 1'b0) begin
        if (rq.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL wb_spurious: got wb_w_en=%b addr %h expected no retire (cycle %0d)", wb_w_en, wb_w_addr, cyc);
        end else begin
          e = rq.pop_front();
          check("wb_cycle", cyc, e.cyc);
          check("wb_w_addr", {27'd0, wb_w_addr}, {27'd0, e.addr});
          check("wb_w_data", wb_w_data, e.data);
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        n_assert++;
        n_fail++;
        $display("FAIL wb_missing: got no retire expected addr %h data %h (cycle %0d)", rq[0].addr, rq[0].data, cyc);
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    id_valid = 0; id_cp0_r_en = 0; id_cp0_r_addr = '0; id_cp0_w_en = 0; id_cp0_w_addr = '0;
    pipe_advance = 0; ex_done = 0; ex_w_data = '0; flush = 0; cp0_rf_data = '0; rst = 1;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    mon_on = 1;

    // Empty scoreboard: read comes from the register file.
    step(1, 1, 12, 0, 0, 0, 0, 0, 0, 32'h1234, 0);

    // MTC0 12 completes on entry, MFC0 12 follows.
    step(1, 0, 0, 1, 12, 1, 1, 32'hA5A5A5A5, 0, 0, 0);
    step(1, 1, 12, 0, 0, 0, 0, 0, 0, 32'h0BAD, 0);
    for (int i = 0; i < DEPTH + 2; i++) step(1, 1, 12, 0, 0, 1, 0, 0, 0, 32'h0BAD, 0);

    // MTC0 11 waits on data for three cycles.
    step(1, 0, 0, 1, 11, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 11, 0, 0, 1, 0, 0, 0, 32'h55, 0);
    step(1, 1, 11, 0, 0, 1, 1, 32'h1111, 0, 32'h55, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Back-to-back writes to 9: youngest (0x1) must win.
    step(1, 0, 0, 1, 9, 1, 1, 32'h2, 0, 0, 0);
    step(1, 0, 0, 1, 9, 1, 1, 32'h1, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0, 0, 0, 0, 32'h77, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Long stall: timeout pulse once, stall held until data arrives.
    step(1, 0, 0, 1, 11, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 11, 0, 0, 0, 0, 0, 0, 32'h66, 0);
    step(1, 1, 11, 0, 0, 0, 1, 32'hCAFE, 0, 32'h66, 0);
    step(1, 1, 11, 0, 0, 1, 0, 0, 0, 32'h66, 0);

    // Flush with three valid slots during a stall.
    step(1, 0, 0, 1, 3, 1, 1, 32'h30, 0, 0, 0);
    step(1, 0, 0, 1, 3, 1, 1, 32'h31, 0, 0, 0);
    step(1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 1, 0, 0, 0, 32'h99, 0);
    step(1, 1, 3, 0, 0, 1, 0, 0, 1, 32'h99, 0);
    step(1, 1, 3, 0, 0, 1, 0, 0, 0, 32'h99, 0);

    // Reset in the middle of a stall.
    step(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 0, 1, 0, 0, 0, 32'h42, 0);
    step(1, 1, 5, 0, 0, 1, 0, 0, 0, 32'h42, 1);
    step(1, 1, 5, 0, 0, 1, 0, 0, 0, 32'h42, 0);

    for (int n = 0; n < 4000; n++) begin
      bit v, re, we;
      v  = ($urandom_range(0, 9) != 0);
      re = ($urandom_range(0, 1) == 1);
      we = !re && ($urandom_range(0, 1) == 1);
      step(v, re, ADDR_W'($urandom_range(0, 3)), we, ADDR_W'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), $urandom(),
           ($urandom_range(0, 99) < 3), $urandom(), ($urandom_range(0, 199) == 0));
    end

    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_assert++;
    if (rq.size() != 0) begin
      n_fail++;
      $display("FAIL wb_drain: got %0d retires outstanding expected 0", rq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
